// File: rtl/maria_bus_arbiter.sv
// Shared-bus arbiter between the 6502 and the Maria DMA engine.
// Sequences HALT request, CPU parking on pclk0, DMA grant, watchdog and bus turnaround.
module maria_bus_arbiter #(
  parameter int unsigned HALT_LATENCY = 1,
  parameter int unsigned TURNAROUND   = 2,
  parameter int unsigned MAX_GRANT    = 512
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       mclk1,
  input  logic       pclk0,
  input  logic       maria_en,
  input  logic       dma_req,
  input  logic       dma_done,
  output logic       halt_n,
  output logic       dma_grant,
  output logic       drive_AB,
  output logic       timeout,
  output logic [1:0] state_o
);

  localparam int unsigned GW = $clog2(MAX_GRANT) + 1;

  localparam logic [1:0]    HL_LAST = 2'(HALT_LATENCY - 1);
  localparam logic [GW-1:0] GM_LAST = GW'(MAX_GRANT - 1);
  localparam logic [2:0]    TA_LAST = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HALT_REQ = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    hcnt_q, hcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [2:0]    tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
  logic          halt_n_q, halt_n_d;
  logic          grant_q, grant_d;
  logic          drive_q, drive_d;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;

    if (!maria_en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      gcnt_d  = '0;
      tcnt_d  = '0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (dma_req) begin
            state_d = HALT_REQ;
            hcnt_d  = '0;
          end
        end
        HALT_REQ: begin
          // a withdrawn request wins over a coincident pclk0 tick
          if (!dma_req) begin
            state_d = IDLE;
            hcnt_d  = '0;
          end else if (pclk0) begin
            if (hcnt_q >= HL_LAST) begin
              state_d = GRANT;
              gcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + 2'd1;
            end
          end
        end
        GRANT: begin
          if (dma_done) begin
            state_d = RELEASE;
            tcnt_d  = '0;
          end else if (mclk1) begin
            if (gcnt_q >= GM_LAST) begin
              state_d   = RELEASE;
              tcnt_d    = '0;
              timeout_d = 1'b1;
            end else begin
              gcnt_d = gcnt_q + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (TURNAROUND == 0) begin
            state_d = IDLE;
          end else if (mclk1) begin
            if (tcnt_q >= TA_LAST) begin
              state_d = IDLE;
            end else begin
              tcnt_d = tcnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they land on the transition edge
  always_comb begin
    halt_n_d = (state_d == IDLE);
    grant_d  = (state_d == GRANT);
    drive_d  = (state_d == GRANT);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      halt_n_q  <= 1'b1;
      grant_q   <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      halt_n_q  <= halt_n_d;
      grant_q   <= grant_d;
      drive_q   <= drive_d;
    end
  end

  assign halt_n    = halt_n_q;
  assign dma_grant = grant_q;
  assign drive_AB  = drive_q;
  assign timeout   = timeout_q;
  assign state_o   = state_q;

endmodule
